mem_load_unit: RTL and testbench
================================

Name: mem_load_unit

Overview:
- Memory-stage consumer of the data SRAM port driven by the execute stage; it is the read side of that interface.
- Registers the execute-to-memory handoff and captures data_sram_rdata one cycle after each request.
- Extracts and sign/zero-extends load data, including LWL/LWR merges with the forwarded rt value.
- Holds captured read data while writeback stalls, and presents results, forwarding data and a valid/allowin handshake to writeback.

Parameters:
- None. The data width is fixed at 32 bits.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ex_from_ws  in  1  exception flush from writeback
es_to_ms_valid  in  1  execute stage has an instruction
ms_allowin  out  1  memory stage accepts this cycle
es_load_op  in  3  0 none, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 LWL, 7 LWR
es_alu_result  in  32  address or ALU result
es_rt_value  in  32  forwarded rt, used for LWL/LWR merge
es_gr_we  in  1  register write enable
es_dest  in  5  destination register
es_pc  in  32  instruction PC
es_ex  in  1  instruction already carries an exception
data_sram_rdata  in  32  SRAM read data, valid the cycle after the request
ws_allowin  in  1  writeback accepts
ms_to_ws_valid  out  1  result valid to writeback
ms_final_result  out  32  load or ALU result
ms_gr_we  out  1  register write enable, gated by valid and no exception
ms_dest  out  5  destination register
ms_pc  out  32  PC
ms_ex  out  1  exception flag passed through
ms_fwd_data  out  32  equals ms_final_result
ms_fwd_valid  out  1  ms_valid & ms_gr_we & data available

Behaviour:
- Reset or ex_from_ws clears:
  - ms_valid, first_r, buf_valid;
  - all outputs derived from them: ms_to_ws_valid=0, ms_gr_we=0, ms_fwd_valid=0.
  - The flush has priority over a simultaneous accept.
- Accept:
  - ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
  - On es_to_ms_valid & ms_allowin, latch all es_* fields, set ms_valid=1 and first_r=1.
  - If ms_allowin is high with es_to_ms_valid low, ms_valid becomes 0.
- Read-data timing:
  - data_sram_rdata is valid only in the cycle where first_r=1.
  - first_r clears on the next clock unless a new instruction is accepted in that cycle.
- Data source selection:
  - rdata_eff = first_r ? data_sram_rdata : rdata_buf.
  - If first_r & ms_valid & !ws_allowin, capture rdata_buf <= data_sram_rdata and set buf_valid=1.
  - buf_valid clears when the instruction leaves (ms_to_ws_valid & ws_allowin).
  - A new instruction never uses a stale buffer.
- Completion:
  - ms_ready_go = 1 when first_r | buf_valid | es_load_op==0.
  - A load with neither first_r nor buf_valid cannot occur; an assertion checks this.
  - ms_to_ws_valid = ms_valid & ms_ready_go.
- Extraction (little-endian), with a = es_alu_result[1:0] latched:
  - LW: rdata_eff.
  - LB/LBU: byte a, sign- or zero-extended.
  - LH/LHU: halfword a[1], sign- or zero-extended.
  - LWL by a:
    - a=0: {b0, rt[23:0]}
    - a=1: {rdata[15:0], rt[15:0]}
    - a=2: {rdata[23:0], rt[7:0]}
    - a=3: rdata
  - LWR by a:
    - a=0: rdata
    - a=1: {rt[31:24], rdata[31:8]}
    - a=2: {rt[31:16], rdata[31:16]}
    - a=3: {rt[31:8], rdata[31:24]}
  - Non-load: es_alu_result.
- Exceptions:
  - ms_ex=1 forces ms_gr_we=0.
  - Extraction output is don't-care, but no X may propagate on ms_gr_we.
- Back-to-back:
  - A new load is accepted in the same cycle the previous one leaves.
  - first_r stays 1 and the buffer clears.
- Latency: 1 cycle from accept to ms_to_ws_valid, if ws_allowin.

Test Plan:
- LB, addr low=2'b11, rdata=32'h80_12_34_56 -> ms_final_result=32'hFFFFFF80, ms_gr_we=1. Same case as LBU -> 32'h00000080.
- LWL, a=1, rdata=32'hAABBCCDD, rt=32'h11223344 -> 32'hCCDD3344. LWR, a=2, same values -> 32'h1122AABB.
- LW issued, ws_allowin=0 for 3 cycles while data_sram_rdata changes to 32'hDEADBEEF after cycle 1 (original 32'h12345678) -> output stays 32'h12345678, ms_to_ws_valid held high, ms_allowin=0 until ws_allowin=1.
- Three back-to-back LHs at addr low 0, 2, 0 with halfwords 8001/7FFF/0000 -> results 32'hFFFF8001, 32'h00007FFF, 32'h00000000 on consecutive cycles.
- ex_from_ws asserted while a stalled load holds buf_valid=1 and es_to_ms_valid=1 -> next cycle ms_valid=0 and buf_valid=0. The following load returns fresh rdata.
- Load with es_ex=1 -> ms_ex=1, ms_gr_we=0, ms_fwd_valid=0. Reset mid-stall -> all valids 0 on the next edge.

Source files
------------

// File: rtl/mem_load_unit.sv
// ----------------------------------------------------------------------------
// mem_load_unit
//
// Memory stage of the pipeline, read side of the data SRAM port. It registers
// the execute-to-memory handoff and picks up data_sram_rdata in the cycle
// after the request. The block then extracts and sign/zero-extends the load
// data, including the LWL/LWR merges with the forwarded rt value. While
// writeback stalls, it holds the captured read data and presents the result
// to writeback with a valid/allowin handshake.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   ex_from_ws        exception flush from writeback (clears the stage)
//   es_to_ms_valid    execute stage presents an instruction
//   ms_allowin        memory stage accepts an instruction this cycle
//   es_*              execute-stage fields latched on accept
//   data_sram_rdata   SRAM read data, valid the cycle after the request
//   ws_allowin        writeback accepts this cycle
//   ms_to_ws_valid    result valid towards writeback
//   ms_final_result   load or ALU result
//   ms_gr_we          register write enable, gated by valid and exception
//   ms_dest, ms_pc    destination register and PC of the held instruction
//   ms_ex             exception flag passed through
//   ms_fwd_data       forwarding data (equals ms_final_result)
//   ms_fwd_valid      forwarding data is valid and will be written
// ----------------------------------------------------------------------------
module mem_load_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_from_ws,
    input  logic        es_to_ms_valid,
    output logic        ms_allowin,
    input  logic [2:0]  es_load_op,
    input  logic [31:0] es_alu_result,
    input  logic [31:0] es_rt_value,
    input  logic        es_gr_we,
    input  logic [4:0]  es_dest,
    input  logic [31:0] es_pc,
    input  logic        es_ex,
    input  logic [31:0] data_sram_rdata,
    input  logic        ws_allowin,
    output logic        ms_to_ws_valid,
    output logic [31:0] ms_final_result,
    output logic        ms_gr_we,
    output logic [4:0]  ms_dest,
    output logic [31:0] ms_pc,
    output logic        ms_ex,
    output logic [31:0] ms_fwd_data,
    output logic        ms_fwd_valid
);

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_W    = 3'd1,
        LD_H    = 3'd2,
        LD_HU   = 3'd3,
        LD_B    = 3'd4,
        LD_BU   = 3'd5,
        LD_WL   = 3'd6,
        LD_WR   = 3'd7
    } load_op_e;

    // Stage control state
    logic        ms_valid_q;
    logic        first_q;      // SRAM read data is on data_sram_rdata this cycle
    logic        buf_valid_q;  // rdata_buf_q holds the read data of the current load
    logic [31:0] rdata_buf_q;

    // Latched execute-stage fields
    load_op_e    load_op_q;
    logic [31:0] alu_result_q;
    logic [31:0] rt_value_q;
    logic        gr_we_q;
    logic [4:0]  dest_q;
    logic [31:0] pc_q;
    logic        ex_q;

    logic        ms_ready_go;
    logic        accept;
    logic [31:0] rdata_eff;
    logic [1:0]  addr_lo;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_result;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    assign ms_ready_go    = first_q | buf_valid_q | (load_op_q == LD_NONE);
    assign ms_allowin     = !ms_valid_q | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid_q & ms_ready_go;
    assign accept         = es_to_ms_valid & ms_allowin;

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset || ex_from_ws) begin
            // A flush wins over a simultaneous accept.
            ms_valid_q  <= 1'b0;
            first_q     <= 1'b0;
            buf_valid_q <= 1'b0;
        end else begin
            if (ms_allowin) begin
                ms_valid_q <= es_to_ms_valid;
            end

            if (accept) begin
                // A new instruction starts with its read data on the SRAM
                // port next cycle, so any earlier buffer is discarded.
                first_q     <= 1'b1;
                buf_valid_q <= 1'b0;
            end else begin
                first_q <= 1'b0;
                if (first_q && ms_valid_q && !ws_allowin) begin
                    buf_valid_q <= 1'b1;
                end else if (ms_to_ws_valid && ws_allowin) begin
                    buf_valid_q <= 1'b0;
                end
            end
        end
    end

    // Control-relevant fields are reset so no X reaches ms_gr_we.
    always_ff @(posedge clk) begin
        if (reset) begin
            load_op_q <= LD_NONE;
            gr_we_q   <= 1'b0;
            ex_q      <= 1'b0;
        end else if (accept) begin
            load_op_q <= load_op_e'(es_load_op);
            gr_we_q   <= es_gr_we;
            ex_q      <= es_ex;
        end
    end

    // NOTE: pure datapath registers carry no reset; they are only consumed
    // while ms_valid_q/buf_valid_q qualify them.
    always_ff @(posedge clk) begin
        if (accept) begin
            alu_result_q <= es_alu_result;
            rt_value_q   <= es_rt_value;
            dest_q       <= es_dest;
            pc_q         <= es_pc;
        end
        if (first_q && ms_valid_q && !ws_allowin) begin
            rdata_buf_q <= data_sram_rdata;
        end
    end

    // ------------------------------------------------------------------------
    // Load data extraction (little-endian)
    // ------------------------------------------------------------------------
    assign rdata_eff = first_q ? data_sram_rdata : rdata_buf_q;
    assign addr_lo   = alu_result_q[1:0];
    assign ld_half   = addr_lo[1] ? rdata_eff[31:16] : rdata_eff[15:0];

    always_comb begin
        ld_byte = rdata_eff[7:0];
        case (addr_lo)
            2'd0: ld_byte = rdata_eff[7:0];
            2'd1: ld_byte = rdata_eff[15:8];
            2'd2: ld_byte = rdata_eff[23:16];
            2'd3: ld_byte = rdata_eff[31:24];
            default: ld_byte = rdata_eff[7:0];
        endcase
    end

    always_comb begin
        load_result = alu_result_q;
        case (load_op_q)
            LD_NONE: load_result = alu_result_q;
            LD_W:    load_result = rdata_eff;
            LD_H:    load_result = {{16{ld_half[15]}}, ld_half};
            LD_HU:   load_result = {16'h0000, ld_half};
            LD_B:    load_result = {{24{ld_byte[7]}}, ld_byte};
            LD_BU:   load_result = {24'h000000, ld_byte};
            LD_WL: begin
                // Unaligned-left: memory bytes fill the upper part of rt.
                case (addr_lo)
                    2'd0: load_result = {rdata_eff[7:0],  rt_value_q[23:0]};
                    2'd1: load_result = {rdata_eff[15:0], rt_value_q[15:0]};
                    2'd2: load_result = {rdata_eff[23:0], rt_value_q[7:0]};
                    default: load_result = rdata_eff;
                endcase
            end
            LD_WR: begin
                // Unaligned-right: memory bytes fill the lower part of rt.
                case (addr_lo)
                    2'd0: load_result = rdata_eff;
                    2'd1: load_result = {rt_value_q[31:24], rdata_eff[31:8]};
                    2'd2: load_result = {rt_value_q[31:16], rdata_eff[31:16]};
                    default: load_result = {rt_value_q[31:8], rdata_eff[31:24]};
                endcase
            end
            default: load_result = alu_result_q;
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ms_final_result = load_result;
    assign ms_fwd_data     = load_result;
    assign ms_gr_we        = ms_valid_q & gr_we_q & !ex_q;
    assign ms_fwd_valid    = ms_gr_we & ms_ready_go;
    assign ms_dest         = dest_q;
    assign ms_pc           = pc_q;
    assign ms_ex           = ex_q;

    // A valid load must always have its data either on the port or buffered.
    a_load_has_data : assert property (
        @(posedge clk) disable iff (reset)
        (ms_valid_q && load_op_q != LD_NONE) |-> (first_q || buf_valid_q)
    );

endmodule

// File: tb/tb_mem_load_unit.sv
// ----------------------------------------------------------------------------
// tb_mem_load_unit
//
// Directed bench for mem_load_unit. Single loads are driven from a table of
// records with hand-computed results. Hand-written sequences cover writeback
// stalls, back-to-back loads, flushes, exceptions and reset during a stall.
// ----------------------------------------------------------------------------
module tb_mem_load_unit;

    logic        clk;
    logic        reset;
    logic        ex_from_ws;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic [2:0]  es_load_op;
    logic [31:0] es_alu_result;
    logic [31:0] es_rt_value;
    logic        es_gr_we;
    logic [4:0]  es_dest;
    logic [31:0] es_pc;
    logic        es_ex;
    logic [31:0] data_sram_rdata;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [31:0] ms_final_result;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_pc;
    logic        ms_ex;
    logic [31:0] ms_fwd_data;
    logic        ms_fwd_valid;

    int n_checks = 0;
    int n_fail   = 0;

    mem_load_unit dut (
        .clk             (clk),
        .reset           (reset),
        .ex_from_ws      (ex_from_ws),
        .es_to_ms_valid  (es_to_ms_valid),
        .ms_allowin      (ms_allowin),
        .es_load_op      (es_load_op),
        .es_alu_result   (es_alu_result),
        .es_rt_value     (es_rt_value),
        .es_gr_we        (es_gr_we),
        .es_dest         (es_dest),
        .es_pc           (es_pc),
        .es_ex           (es_ex),
        .data_sram_rdata (data_sram_rdata),
        .ws_allowin      (ws_allowin),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_final_result (ms_final_result),
        .ms_gr_we        (ms_gr_we),
        .ms_dest         (ms_dest),
        .ms_pc           (ms_pc),
        .ms_ex           (ms_ex),
        .ms_fwd_data     (ms_fwd_data),
        .ms_fwd_valid    (ms_fwd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] OP_NONE = 3'd0, OP_W = 3'd1, OP_H = 3'd2, OP_HU = 3'd3,
                           OP_B = 3'd4, OP_BU = 3'd5, OP_WL = 3'd6, OP_WR = 3'd7;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] rt;
        logic        gr_we;
        logic [31:0] exp_result;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present one instruction to the stage; accepted at the next posedge.
    task automatic drive_es(input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] rt, input logic gr_we,
                            input logic [4:0] dest, input logic [31:0] pc,
                            input logic ex);
        es_to_ms_valid = 1'b1;
        es_load_op     = op;
        es_alu_result  = addr;
        es_rt_value    = rt;
        es_gr_we       = gr_we;
        es_dest        = dest;
        es_pc          = pc;
        es_ex          = ex;
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset           = 1'b1;
        ex_from_ws      = 1'b0;
        es_to_ms_valid  = 1'b0;
        es_load_op      = OP_NONE;
        es_alu_result   = '0;
        es_rt_value     = '0;
        es_gr_we        = 1'b0;
        es_dest         = '0;
        es_pc           = '0;
        es_ex           = 1'b0;
        data_sram_rdata = '0;
        ws_allowin      = 1'b1;

        // Single-load vectors, rt = 32'h11223344 unless noted.
        vecs.push_back('{"LB a3",    OP_B,    32'h1000_0003, 32'h8012_3456, 32'h1122_3344, 1'b1, 32'hFFFF_FF80});
        vecs.push_back('{"LBU a3",   OP_BU,   32'h1000_0003, 32'h8012_3456, 32'h1122_3344, 1'b1, 32'h0000_0080});
        vecs.push_back('{"LB a1",    OP_B,    32'h1000_0001, 32'h8012_3456, 32'h1122_3344, 1'b1, 32'h0000_0034});
        vecs.push_back('{"LB a0",    OP_B,    32'h1000_0000, 32'h1234_56F0, 32'h1122_3344, 1'b1, 32'hFFFF_FFF0});
        vecs.push_back('{"LWL a1",   OP_WL,   32'h1000_0001, 32'hAABB_CCDD, 32'h1122_3344, 1'b1, 32'hCCDD_3344});
        vecs.push_back('{"LWR a2",   OP_WR,   32'h1000_0002, 32'hAABB_CCDD, 32'h1122_3344, 1'b1, 32'h1122_AABB});
        vecs.push_back('{"LWL a0",   OP_WL,   32'h1000_0000, 32'hAABB_CCDD, 32'h1122_3344, 1'b1, 32'hDD22_3344});
        vecs.push_back('{"LWL a2",   OP_WL,   32'h1000_0002, 32'hAABB_CCDD, 32'h1122_3344, 1'b1, 32'hBBCC_DD44});
        vecs.push_back('{"LWL a3",   OP_WL,   32'h1000_0003, 32'hAABB_CCDD, 32'h1122_3344, 1'b1, 32'hAABB_CCDD});
        vecs.push_back('{"LWR a0",   OP_WR,   32'h1000_0000, 32'hAABB_CCDD, 32'h1122_3344, 1'b1, 32'hAABB_CCDD});
        vecs.push_back('{"LWR a1",   OP_WR,   32'h1000_0001, 32'hAABB_CCDD, 32'h1122_3344, 1'b1, 32'h11AA_BBCC});
        vecs.push_back('{"LWR a3",   OP_WR,   32'h1000_0003, 32'hAABB_CCDD, 32'h1122_3344, 1'b1, 32'h1122_33AA});
        vecs.push_back('{"LW",       OP_W,    32'h1000_0000, 32'h1234_5678, 32'h1122_3344, 1'b1, 32'h1234_5678});
        vecs.push_back('{"LH a2",    OP_H,    32'h1000_0002, 32'h8012_3456, 32'h1122_3344, 1'b1, 32'hFFFF_8012});
        vecs.push_back('{"LHU a2",   OP_HU,   32'h1000_0002, 32'h8012_3456, 32'h1122_3344, 1'b1, 32'h0000_8012});
        vecs.push_back('{"LH a0",    OP_H,    32'h1000_0000, 32'h8012_3456, 32'h1122_3344, 1'b1, 32'h0000_3456});
        vecs.push_back('{"ALU",      OP_NONE, 32'h0000_1237, 32'hFFFF_FFFF, 32'h1122_3344, 1'b1, 32'h0000_1237});
        vecs.push_back('{"ALU nowe", OP_NONE, 32'h0BAD_0001, 32'hFFFF_FFFF, 32'h1122_3344, 1'b0, 32'h0BAD_0001});

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst ms_to_ws_valid", 32'(ms_to_ws_valid), 32'd0);
        check("rst ms_gr_we",       32'(ms_gr_we),       32'd0);
        check("rst ms_fwd_valid",   32'(ms_fwd_valid),   32'd0);
        check("rst ms_allowin",     32'(ms_allowin),     32'd1);
        reset = 1'b0;

        // ---------------- table-driven single loads ----------------
        foreach (vecs[i]) begin
            drive_es(vecs[i].op, vecs[i].addr, vecs[i].rt, vecs[i].gr_we, 5'(i + 1), 32'hBFC0_0000 + 32'(i * 4), 1'b0);
            step();
            es_to_ms_valid  = 1'b0;
            data_sram_rdata = vecs[i].rdata;
            #1;
            check({vecs[i].name, " valid"},  32'(ms_to_ws_valid), 32'd1);
            check({vecs[i].name, " result"}, ms_final_result,     vecs[i].exp_result);
            check({vecs[i].name, " fwd"},    ms_fwd_data,         vecs[i].exp_result);
            check({vecs[i].name, " gr_we"},  32'(ms_gr_we),       32'(vecs[i].gr_we));
            check({vecs[i].name, " fwd_v"},  32'(ms_fwd_valid),   32'(vecs[i].gr_we));
            check({vecs[i].name, " dest"},   32'(ms_dest),        32'(i + 1));
            check({vecs[i].name, " pc"},     ms_pc,               32'hBFC0_0000 + 32'(i * 4));
            step();
            check({vecs[i].name, " drained"}, 32'(ms_to_ws_valid), 32'd0);
        end

        // ---------------- stall: LW held while writeback stalls ----------------
        ws_allowin = 1'b0;
        drive_es(OP_W, 32'h2000_0000, 32'h0, 1'b1, 5'd3, 32'h0000_0100, 1'b0);
        step();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h1234_5678;
        #1;
        check("stall c1 result",  ms_final_result,     32'h1234_5678);
        check("stall c1 valid",   32'(ms_to_ws_valid), 32'd1);
        check("stall c1 allowin", 32'(ms_allowin),     32'd0);
        for (int c = 2; c <= 3; c++) begin
            step();
            data_sram_rdata = 32'hDEAD_BEEF;
            #1;
            check($sformatf("stall c%0d result", c),  ms_final_result,     32'h1234_5678);
            check($sformatf("stall c%0d valid", c),   32'(ms_to_ws_valid), 32'd1);
            check($sformatf("stall c%0d allowin", c), 32'(ms_allowin),     32'd0);
        end
        step();
        ws_allowin = 1'b1;
        #1;
        check("stall release result",  ms_final_result, 32'h1234_5678);
        check("stall release allowin", 32'(ms_allowin), 32'd1);
        step();
        check("stall drained", 32'(ms_to_ws_valid), 32'd0);

        // ---------------- back-to-back LH at addr 0, 2, 0 ----------------
        drive_es(OP_H, 32'h3000_0000, 32'h0, 1'b1, 5'd4, 32'h0000_0200, 1'b0);
        step();
        data_sram_rdata = 32'h5555_8001;
        drive_es(OP_H, 32'h3000_0002, 32'h0, 1'b1, 5'd5, 32'h0000_0204, 1'b0);
        #1;
        check("b2b 1 result",  ms_final_result, 32'hFFFF_8001);
        check("b2b 1 allowin", 32'(ms_allowin), 32'd1);
        step();
        data_sram_rdata = 32'h7FFF_1234;
        drive_es(OP_H, 32'h3000_0000, 32'h0, 1'b1, 5'd6, 32'h0000_0208, 1'b0);
        #1;
        check("b2b 2 result", ms_final_result,     32'h0000_7FFF);
        check("b2b 2 valid",  32'(ms_to_ws_valid), 32'd1);
        check("b2b 2 dest",   32'(ms_dest),        32'd5);
        step();
        data_sram_rdata = 32'h5555_0000;
        es_to_ms_valid  = 1'b0;
        #1;
        check("b2b 3 result", ms_final_result,     32'h0000_0000);
        check("b2b 3 valid",  32'(ms_to_ws_valid), 32'd1);
        step();
        check("b2b drained", 32'(ms_to_ws_valid), 32'd0);

        // ---------------- flush while a stalled load holds the buffer ----------------
        ws_allowin = 1'b0;
        drive_es(OP_W, 32'h4000_0000, 32'h0, 1'b1, 5'd7, 32'h0000_0300, 1'b0);
        step();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'hCAFE_F00D;
        step();
        data_sram_rdata = 32'h0;
        check("flush pre buf_valid", 32'(dut.buf_valid_q), 32'd1);
        drive_es(OP_W, 32'h4000_0004, 32'h0, 1'b1, 5'd8, 32'h0000_0304, 1'b0);
        ex_from_ws = 1'b1;
        step();
        ex_from_ws     = 1'b0;
        es_to_ms_valid = 1'b0;
        #1;
        check("flush valid",     32'(ms_to_ws_valid),  32'd0);
        check("flush ms_valid",  32'(dut.ms_valid_q),  32'd0);
        check("flush buf_valid", 32'(dut.buf_valid_q), 32'd0);
        check("flush allowin",   32'(ms_allowin),      32'd1);
        // Following load stalls one cycle and must return its own data.
        drive_es(OP_W, 32'h4000_0008, 32'h0, 1'b1, 5'd9, 32'h0000_0308, 1'b0);
        step();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h0BAD_CAFE;
        #1;
        check("post-flush c1 result", ms_final_result, 32'h0BAD_CAFE);
        step();
        data_sram_rdata = 32'hFFFF_FFFF;
        #1;
        check("post-flush c2 result", ms_final_result,     32'h0BAD_CAFE);
        check("post-flush c2 valid",  32'(ms_to_ws_valid), 32'd1);
        ws_allowin = 1'b1;
        step();
        check("post-flush drained", 32'(ms_to_ws_valid), 32'd0);

        // ---------------- load carrying an exception ----------------
        drive_es(OP_W, 32'h5000_0000, 32'h0, 1'b1, 5'd10, 32'h0000_0400, 1'b1);
        step();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h1111_2222;
        #1;
        check("ex ms_ex",       32'(ms_ex),          32'd1);
        check("ex ms_gr_we",    32'(ms_gr_we),       32'd0);
        check("ex ms_fwd_valid", 32'(ms_fwd_valid),  32'd0);
        check("ex valid",       32'(ms_to_ws_valid), 32'd1);
        step();
        es_ex = 1'b0;

        // ---------------- reset during a stall ----------------
        ws_allowin = 1'b0;
        drive_es(OP_W, 32'h6000_0000, 32'h0, 1'b1, 5'd11, 32'h0000_0500, 1'b0);
        step();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h3333_4444;
        step();
        check("pre-rst valid", 32'(ms_to_ws_valid), 32'd1);
        reset = 1'b1;
        step();
        check("mid-rst valid",      32'(ms_to_ws_valid), 32'd0);
        check("mid-rst gr_we",      32'(ms_gr_we),       32'd0);
        check("mid-rst fwd_valid",  32'(ms_fwd_valid),   32'd0);
        check("mid-rst allowin",    32'(ms_allowin),     32'd1);
        reset      = 1'b0;
        ws_allowin = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
